// File: rtl/keypad_scan_rx_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_rx_if
// Purpose : valid/ready handshake that carries debounced key codes from the
//           keypad scanner (master) to the consuming FSM / matrix-entry logic
//           (slave).
// Signals : key_code  [3:0]  head code {row[1:0], col[1:0]}, master -> slave
//           key_valid        head code present, master -> slave
//           key_ready        consumer takes the head this cycle, slave -> master
// -----------------------------------------------------------------------------
interface keypad_scan_rx_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_rx.sv
// -----------------------------------------------------------------------------
// keypad_scan_rx
// Purpose : scans a 4x4 matrix keypad (drives one column low at a time, reads
//           the rows), debounces press and release, encodes the captured key as
//           {row[1:0], col[1:0]} and queues it in a small FIFO read out through
//           a valid/ready handshake.
// Ports   : clk          system clock
//           rst_n        asynchronous active-low reset, release synchronized
//           row_n  [3:0] keypad rows, active-low, asynchronous to clk
//           col_n  [3:0] column drive, one-hot active-low
//           key_pressed  high while a debounced key is held
//           overflow     one-cycle pulse when a code is dropped (FIFO full)
//           kif          keypad_scan_rx_if.master (key_code/key_valid/key_ready)
// Options : define KEYPAD_REPEAT_EN to auto-repeat a held key's code after
//           REPEAT_DELAY ticks and then every REPEAT_RATE ticks.
// -----------------------------------------------------------------------------
module keypad_scan_rx #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEB_CNT      = 20,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              row_n,
    output logic [3:0]              col_n,
    output logic                    key_pressed,
    output logic                    overflow,
    keypad_scan_rx_if.master        kif
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] REP_ONE        = RW'(1);
`endif

    // Lowest-index active (low) row wins when several rows are down.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0]) begin
            return 2'd0;
        end else if (!r[1]) begin
            return 2'd1;
        end else if (!r[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    logic [1:0]    rst_sync_q;
    logic          rst_int_n;
    logic [3:0]    row_meta_q, row_sync_q;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_s;
    logic [1:0]    state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [DW-1:0] rel_cnt_q, rel_cnt_d;
    logic          push_q, push_d;
    logic [3:0]    push_code_q, push_code_d;
    logic [3:0]    col_n_q, col_n_d;
    logic          key_pressed_q, key_pressed_d;
    logic          row_low_s, any_low_s;
`ifdef KEYPAD_REPEAT_EN
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
`endif

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_s, wr_ok_s;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overflow_q, overflow_d;

    // Reset synchronizer: assert immediately, release two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Two-flop synchronizer for the asynchronous keypad rows.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    assign tick_s    = (tick_cnt_q == TICK_LAST);
    assign row_low_s = ~row_sync_q[row_idx_q];
    assign any_low_s = (row_sync_q != 4'hF);

    // Scan / debounce / hold state machine; rows are only looked at on ticks.
    always_comb begin
        tick_cnt_d  = tick_s ? '0 : (tick_cnt_q + TICK_ONE);
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (tick_s) begin
                    if (any_low_s) begin
                        row_idx_d = lowest_low(row_sync_q);
                        if (DEB_LAST == DEB_ONE) begin
                            push_d      = 1'b1;
                            push_code_d = {lowest_low(row_sync_q), col_idx_q};
                            state_d     = ST_HELD;
                            deb_cnt_d   = '0;
                            rel_cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b1;
`endif
                        end else begin
                            deb_cnt_d = DEB_ONE;
                            state_d   = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (tick_s) begin
                    if (row_low_s) begin
                        if ((deb_cnt_q + DEB_ONE) == DEB_LAST) begin
                            push_d      = 1'b1;
                            push_code_d = {row_idx_q, col_idx_q};
                            state_d     = ST_HELD;
                            deb_cnt_d   = '0;
                            rel_cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b1;
`endif
                        end else begin
                            deb_cnt_d = deb_cnt_q + DEB_ONE;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        deb_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_HELD: begin
                if (tick_s) begin
                    if (!row_low_s) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d = '0;
`endif
                        if ((rel_cnt_q + DEB_ONE) == DEB_LAST) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                            rel_cnt_d = '0;
                        end else begin
                            rel_cnt_d = rel_cnt_q + DEB_ONE;
                        end
                    end else begin
                        rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        // First repeat waits the long delay, later ones the rate.
                        if ((rep_first_q && ((rep_cnt_q + REP_ONE) == REP_DELAY_LAST)) ||
                            (!rep_first_q && ((rep_cnt_q + REP_ONE) == REP_RATE_LAST))) begin
                            push_d      = 1'b1;
                            push_code_d = {row_idx_q, col_idx_q};
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
`endif
                    end
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d   = ST_SCAN;
                col_idx_d = 2'd0;
                deb_cnt_d = '0;
                rel_cnt_d = '0;
            end
        endcase
        col_n_d       = ~(4'b0001 << col_idx_d);
        key_pressed_d = (state_d == ST_HELD);
    end

    // Code FIFO; key_code is the registered head after this cycle's push/pop.
    always_comb begin
        pop_s      = key_valid_q && kif.key_ready;
        wr_ok_s    = push_q && ((count_q != CNT_FULL) || pop_s);
        overflow_d = push_q && (count_q == CNT_FULL) && !pop_s;
        mem_d      = mem_q;
        if (wr_ok_s) begin
            mem_d[wr_ptr_q] = push_code_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d     = count_q + CW'(wr_ok_s) - CW'(pop_s);
        key_valid_d = (count_d != '0);
        key_code_d  = mem_d[rd_ptr_d];
    end

    // State, counters, FIFO storage and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            tick_cnt_q    <= '0;
            state_q       <= ST_SCAN;
            col_idx_q     <= 2'd0;
            row_idx_q     <= 2'd0;
            deb_cnt_q     <= '0;
            rel_cnt_q     <= '0;
            push_q        <= 1'b0;
            push_code_q   <= 4'h0;
            col_n_q       <= 4'b1110;
            key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q     <= '0;
            rep_first_q   <= 1'b1;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            deb_cnt_q     <= deb_cnt_d;
            rel_cnt_q     <= rel_cnt_d;
            push_q        <= push_d;
            push_code_q   <= push_code_d;
            col_n_q       <= col_n_d;
            key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q     <= rep_cnt_d;
            rep_first_q   <= rep_first_d;
`endif
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign col_n         = col_n_q;
    assign key_pressed   = key_pressed_q;
    assign overflow      = overflow_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_rx.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_rx
// Directed, self-checking bench for keypad_scan_rx with SCAN_DIV=4, DEB_CNT=3,
// FIFO_DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=5. A behavioural keypad pulls the
// selected row low whenever its column is driven. Stimulus changes only at
// dwell boundaries (the edge where col_n may change), so each dwell yields
// exactly one row sample at its closing tick.
// -----------------------------------------------------------------------------
module tb_keypad_scan_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_pressed;
    logic       overflow;

    logic       key_down = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [1:0] key_col  = 2'd0;

    int errors = 0;
    int checks = 0;
    logic [3:0] popped [$];
    int valid_cycles = 0;
    int ovf_cycles   = 0;

    keypad_scan_rx_if kif ();

    keypad_scan_rx #(
        .SCAN_DIV    (4),
        .DEB_CNT     (3),
        .FIFO_DEPTH  (4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_pressed(key_pressed),
        .overflow   (overflow),
        .kif        (kif)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key connects its row to its column.
    always_comb begin
        row_n = 4'hF;
        if (key_down && (col_n[key_col] == 1'b0)) begin
            row_n[key_row] = 1'b0;
        end
    end

    // Consumer side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (kif.key_valid && kif.key_ready) popped.push_back(kif.key_code);
        if (kif.key_valid) valid_cycles++;
        if (overflow) ovf_cycles++;
    end

    task automatic step_dwell(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        popped.delete();
        valid_cycles = 0;
        ovf_cycles   = 0;
    endtask

    // Lock onto the dwell phase: stop just after the first col_n change.
    task automatic align();
        logic [3:0] prev;
        bit found;
        prev  = col_n;
        found = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (col_n !== prev) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL align: col_n stuck at %b", col_n); end
    endtask

    task automatic wait_col(input logic [1:0] c);
        logic [3:0] target;
        target = ~(4'b0001 << c);
        for (int i = 0; i < 8; i++) begin
            if (col_n === target) break;
            step_dwell(1);
        end
        checks++;
        if (col_n !== target) begin errors++; $display("FAIL wait_col: col_n=%b expected %b", col_n, target); end
    endtask

    task automatic press_release(input logic [1:0] r, input logic [1:0] c);
        wait_col(c);
        key_row  = r;
        key_col  = c;
        key_down = 1'b1;
        step_dwell(4);
        key_down = 1'b0;
        step_dwell(4);
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b1011; exp_seq[1] = 4'b0111; exp_seq[2] = 4'b1110; exp_seq[3] = 4'b1101;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b expected 1110", col_n); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", kif.key_valid); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b expected 0", key_pressed); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (kif.key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", kif.key_code); end
        rst_n = 1'b1;
        align();
        checks++; if (col_n !== 4'b1101) begin errors++; $display("FAIL scan_first: got %b expected 1101", col_n); end
        for (int k = 0; k < 4; k++) begin
            logic [3:0] prev;
            prev = col_n;
            repeat (3) @(posedge clk);
            #1;
            checks++; if (col_n !== prev) begin errors++; $display("FAIL scan_hold%0d: got %b expected %b", k, col_n, prev); end
            @(posedge clk);
            #1;
            checks++; if (col_n !== exp_seq[k]) begin errors++; $display("FAIL scan_step%0d: got %b expected %b", k, col_n, exp_seq[k]); end
        end
    endtask

    task automatic test_clean_press();
        kif.key_ready = 1'b1;
        clear_mon();
        wait_col(2'd2);
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        step_dwell(3);
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL clean_pressed: got %b expected 1", key_pressed); end
        checks++; if (popped.size() != 0) begin errors++; $display("FAIL clean_early: got %0d codes expected 0", popped.size()); end
        step_dwell(3);
        checks++; if (popped.size() != 1) begin errors++; $display("FAIL clean_count: got %0d codes expected 1", popped.size()); end
        checks++; if (popped.size() > 0 && popped[0] !== 4'h6) begin errors++; $display("FAIL clean_code: got %h expected 6", popped[0]); end
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL clean_valid_len: got %0d expected 1", valid_cycles); end
        key_down = 1'b0;
        step_dwell(2);
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL clean_rel2: got %b expected 1", key_pressed); end
        step_dwell(1);
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL clean_rel3: got %b expected 0", key_pressed); end
        checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL clean_resume: got %b expected 0111", col_n); end
    endtask

    task automatic test_bounce();
        clear_mon();
        wait_col(2'd2);
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        step_dwell(1);
        key_down = 1'b0;
        step_dwell(1);
        checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL bounce_abort: got %b expected 0111", col_n); end
        key_down = 1'b1;
        step_dwell(5);
        checks++; if (popped.size() != 0) begin errors++; $display("FAIL bounce_early: got %0d codes expected 0", popped.size()); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL bounce_pressed_early: got %b expected 0", key_pressed); end
        step_dwell(1);
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL bounce_accept: got %b expected 1", key_pressed); end
        step_dwell(2);
        checks++; if (popped.size() != 1) begin errors++; $display("FAIL bounce_count: got %0d codes expected 1", popped.size()); end
        checks++; if (popped.size() > 0 && popped[0] !== 4'h6) begin errors++; $display("FAIL bounce_code: got %h expected 6", popped[0]); end
        key_down = 1'b0;
        step_dwell(3);
        // Short press: only two low samples, then release.
        clear_mon();
        wait_col(2'd2);
        key_down = 1'b1;
        step_dwell(2);
        key_down = 1'b0;
        step_dwell(1);
        checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL short_resume: got %b expected 0111", col_n); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL short_pressed: got %b expected 0", key_pressed); end
        step_dwell(8);
        checks++; if (popped.size() != 0) begin errors++; $display("FAIL short_nocode: got %0d codes expected 0", popped.size()); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_codes [4];
        exp_codes[0] = 4'h0; exp_codes[1] = 4'h5; exp_codes[2] = 4'hA; exp_codes[3] = 4'hF;
        kif.key_ready = 1'b0;
        clear_mon();
        press_release(2'd0, 2'd0);
        press_release(2'd1, 2'd1);
        press_release(2'd2, 2'd2);
        press_release(2'd3, 2'd3);
        checks++; if (ovf_cycles != 0) begin errors++; $display("FAIL ovf_none: got %0d pulses expected 0", ovf_cycles); end
        checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", kif.key_valid); end
        checks++; if (kif.key_code !== 4'h0) begin errors++; $display("FAIL ovf_head: got %h expected 0", kif.key_code); end
        press_release(2'd0, 2'd3);
        checks++; if (ovf_cycles != 1) begin errors++; $display("FAIL ovf_pulse: got %0d pulses expected 1", ovf_cycles); end
        kif.key_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (popped.size() != 4) begin errors++; $display("FAIL drain_count: got %0d codes expected 4", popped.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] got;
            got = (i < popped.size()) ? popped[i] : 4'hx;
            checks++; if (got !== exp_codes[i]) begin errors++; $display("FAIL drain_%0d: got %h expected %h", i, got, exp_codes[i]); end
        end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", kif.key_valid); end
    endtask

    task automatic test_hold();
        int exp_n;
        bit all_c;
`ifdef KEYPAD_REPEAT_EN
        exp_n = 11;
`else
        exp_n = 1;
`endif
        kif.key_ready = 1'b1;
        clear_mon();
        wait_col(2'd0);
        key_row = 2'd3; key_col = 2'd0; key_down = 1'b1;
        step_dwell(60);
        key_down = 1'b0;
        step_dwell(6);
        checks++; if (popped.size() != exp_n) begin errors++; $display("FAIL hold_count: got %0d codes expected %0d", popped.size(), exp_n); end
        all_c = 1'b1;
        foreach (popped[i]) if (popped[i] !== 4'hC) all_c = 1'b0;
        checks++; if (!all_c) begin errors++; $display("FAIL hold_code: got non-C code expected all C"); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL hold_released: got %b expected 0", key_pressed); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        wait_col(2'd2);
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        step_dwell(2);
        rst_n = 1'b0;
        #1;
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL mid_col_n: got %b expected 1110", col_n); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL mid_pressed: got %b expected 0", key_pressed); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", kif.key_valid); end
        key_down = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        align();
        checks++; if (col_n !== 4'b1101) begin errors++; $display("FAIL mid_restart: got %b expected 1101", col_n); end
        step_dwell(8);
        checks++; if (popped.size() != 0) begin errors++; $display("FAIL mid_nocode: got %0d codes expected 0", popped.size()); end
    endtask

    initial begin
        kif.key_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_overflow();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan_rx.md
Name: keypad_scan_rx

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver: actively scans a 4x4 matrix keypad by driving columns and reading rows.
- Debounces presses and releases, and encodes each key into a 4-bit code.
- Delivers codes to the central FSM / matrix-entry logic through a small FIFO with a valid/ready handshake.
- Replaces raw push-button sampling for digit and matrix-element entry.

Parameters:
- SCAN_DIV, 100000: clk cycles per column dwell (one "tick"); 1 ms at 100 MHz; must be >= 2.
- DEB_CNT, 20: consecutive identical tick samples needed to accept a press or a release; must be >= 1.
- FIFO_DEPTH, 4: code FIFO entries; power of two, >= 2.
- REPEAT_DELAY, 500: ticks a key is held before the first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 100: ticks between subsequent auto-repeats (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- row_n  in  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
- col_n  out  4  keypad column drive; one-hot active-low.
- key_code  out  4  FIFO head code = {row[1:0], col[1:0]}.
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts the head when key_valid && key_ready.
- key_pressed  out  1  high while a debounced key is held (state HELD).
- overflow  out  1  one-cycle pulse when a code is dropped because the FIFO is full.

Behaviour:
- Reset values (all outputs): col_n=4'b1110, key_code=0, key_valid=0, key_pressed=0, overflow=0; FIFO empty; state SCAN; column index 0; all counters 0.
- Reset is asserted asynchronously; release is synchronized to clk.
- row_n passes through a 2-flop synchronizer before any use.
- Tick generator: counter runs 0..SCAN_DIV-1; a tick fires in the cycle the counter equals SCAN_DIV-1; the counter then wraps to 0. Rows are sampled only on ticks, i.e. at the end of each column's dwell.
- States:
  - SCAN: on each tick, examine the synchronized rows.
    - If any row is low: capture the column index and the lowest-index low row, set deb_cnt=1, go to DEBOUNCE; col_n holds the current column.
    - Otherwise: advance the column index (3 wraps to 0) and update col_n in the same cycle.
  - DEBOUNCE: on each tick, sample the captured row.
    - If still low: deb_cnt++.
    - When deb_cnt reaches DEB_CNT: push the code, go to HELD, clear deb_cnt.
    - If high: no push, go to SCAN, advance the column.
    - With DEB_CNT=1 the push happens on the first tick (SCAN goes straight to HELD).
  - HELD: key_pressed=1; col_n stays fixed. On each tick, sample the captured row.
    - If high: rel_cnt++; when rel_cnt reaches DEB_CNT, go to SCAN, advance the column, clear rel_cnt.
    - If low: rel_cnt=0.
- Multiple keys: only the captured key is tracked. Other keys in the same or other columns are ignored until release.
- Push latency: the code is written to the FIFO on the clock edge after the accepting tick. key_valid rises one cycle after the push when the FIFO was empty.
- FIFO behaviour:
  - key_code is the registered head and stays stable while key_valid && !key_ready.
  - Pop on key_valid && key_ready.
  - Push when full with no simultaneous pop: the code is dropped and overflow pulses for 1 cycle.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: not possible, since key_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
- key_ready while empty is ignored.
- Reset mid-operation: any partially debounced press is discarded with no code pushed; FIFO contents are lost.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- When defined: in HELD, a repeat counter counts ticks while the key stays low (release samples reset it). After REPEAT_DELAY ticks the same code is pushed again, then again every REPEAT_RATE ticks until the release is accepted. Repeats obey the FIFO and overflow rules.
- When undefined: exactly one code per press; the repeat counter and its logic are absent.

Test Plan (SCAN_DIV=4, DEB_CNT=3, FIFO_DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=5):
- Reset: rst_n=0 -> col_n=1110, key_valid=0, key_pressed=0, overflow=0. Rows idle (1111) for 40 cycles -> col_n cycles 1110, 1101, 1011, 0111, changing every 4 clk.
- Clean press of row1/col2 (row_n=1101 whenever col_n=1011, held 3+ ticks) with key_ready=1 -> exactly one code 4'h6; key_valid high 1 cycle; key_pressed=1 until 3 release ticks.
- Bounce: row toggles low, high, low within the DEBOUNCE ticks, then stays low -> no push before 3 consecutive low samples, then one 4'h6. A press lasting only 2 ticks -> no code; scanning resumes.
- Overflow: key_ready=0, five distinct presses 0x0, 0x5, 0xA, 0xF, 0x3 -> key_valid=1, overflow pulses once on the 5th press. Raising key_ready -> drains 0x0, 0x5, 0xA, 0xF in order, then key_valid=0.
- Hold key 0xC for 60 ticks -> without the macro, one code. With KEYPAD_REPEAT_EN, codes at accept, accept+10 ticks, then every 5 ticks (11 total); none after release.
- Reset asserted in DEBOUNCE (deb_cnt=2) -> no code, col_n=1110; after release of rst_n the normal scan restarts.
